// File: rtl/ksw_pkg.sv
// Shared types and constants for the CIGAR extension best-score / Z-drop tracker.
package ksw_pkg;

  localparam int unsigned KswScoreW = 16;
  localparam int unsigned KswPosW   = 16;
  localparam int unsigned KswEW     = 8;
  localparam int unsigned KswDiagW  = 16;

  // Also the compare-tree clear value; marks an anti-diagonal with no live cell.
  localparam logic signed [15:0] NEG_INF = 16'sh8FFF;

  typedef struct packed {
    logic [KswPosW-1:0] i;
    logic [KswPosW-1:0] j;
  } loc_t;

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

endpackage

// File: rtl/ksw_zdrop_eval.sv
// Combinational minimap2-style Z-drop test: fires when best - cur > zdrop + gap_e*|di - dj|.
module ksw_zdrop_eval #(
  parameter int unsigned SCORE_W = 16,
  parameter int unsigned POS_W   = 16,
  parameter int unsigned E_W     = 8
) (
  input  logic signed [SCORE_W-1:0] best_score_i,
  input  logic signed [SCORE_W-1:0] cur_score_i,
  input  logic        [2*POS_W-1:0] best_loc_i,
  input  logic        [2*POS_W-1:0] cur_loc_i,
  input  logic        [SCORE_W-1:0] zdrop_i,
  input  logic        [E_W-1:0]     gap_e_i,
  output logic                      trigger_o
);

  localparam int unsigned PenW = SCORE_W + E_W + POS_W + 2;

  logic signed [POS_W+1:0] di, dj, dd, ad;
  logic        [POS_W:0]   d;
  logic        [PenW-1:0]  pen;
  logic signed [SCORE_W:0] drop;

  always_comb begin
    di   = $signed({2'b00, cur_loc_i[2*POS_W-1:POS_W]}) -
           $signed({2'b00, best_loc_i[2*POS_W-1:POS_W]});
    dj   = $signed({2'b00, cur_loc_i[POS_W-1:0]}) - $signed({2'b00, best_loc_i[POS_W-1:0]});
    dd   = di - dj;
    ad   = dd[POS_W+1] ? -dd : dd;
    d    = ad[POS_W:0];
    pen  = PenW'(zdrop_i) + PenW'(gap_e_i) * PenW'(d);
    drop = $signed({best_score_i[SCORE_W-1], best_score_i}) -
           $signed({cur_score_i[SCORE_W-1], cur_score_i});
    // drop is positive whenever cur < best, so zero-extension is safe.
    trigger_o = (cur_score_i < best_score_i) && (PenW'($unsigned(drop)) > pen);
  end

endmodule

// File: rtl/ksw_best_zdrop_tracker.sv
// Running best score/location over one extension, with early termination when
// KSW_ZDROP_EN is defined; otherwise the extension ends only on the last beat.
module ksw_best_zdrop_tracker
  import ksw_pkg::*;
#(
  parameter int unsigned SCORE_W = KswScoreW,
  parameter int unsigned POS_W   = KswPosW,
  parameter int unsigned E_W     = KswEW,
  parameter int unsigned DIAG_W  = KswDiagW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic        [SCORE_W-1:0] zdrop_i,
  input  logic        [E_W-1:0]     gap_e_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic signed [SCORE_W-1:0] in_max_i,
  input  logic        [2*POS_W-1:0] in_loc_i,
  input  logic                      in_last_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic signed [SCORE_W-1:0] best_score_o,
  output logic        [2*POS_W-1:0] best_loc_o,
  output logic        [DIAG_W-1:0]  diag_cnt_o,
  output logic                      zdropped_o
);

  localparam logic signed [SCORE_W-1:0] NegInf = SCORE_W'(NEG_INF);

  state_e state_q, state_d;
  logic   in_ready_q, busy_q, done_q;

  logic                      p_valid_q, p_last_q;
  logic signed [SCORE_W-1:0] p_max_q;
  logic        [2*POS_W-1:0] p_loc_q;

  logic signed [SCORE_W-1:0] best_q;
  logic        [2*POS_W-1:0] best_loc_q;
  logic        [DIAG_W-1:0]  diag_q;
  logic                      zdropped_q;

  logic accept, launch, eval, better, trigger;

  assign accept = in_valid_i & in_ready_q;
  assign launch = (state_q == StIdle) & start_i;
  assign eval   = p_valid_q;
  assign better = eval && (p_max_q != NegInf) && (p_max_q > best_q);

`ifdef KSW_ZDROP_EN
  logic [SCORE_W-1:0] zdrop_q;
  logic [E_W-1:0]     gap_e_q;
  logic               hit;

  ksw_zdrop_eval #(
    .SCORE_W (SCORE_W),
    .POS_W   (POS_W),
    .E_W     (E_W)
  ) u_zdrop_eval (
    .best_score_i (best_q),
    .cur_score_i  (p_max_q),
    .best_loc_i   (best_loc_q),
    .cur_loc_i    (p_loc_q),
    .zdrop_i      (zdrop_q),
    .gap_e_i      (gap_e_q),
    .trigger_o    (hit)
  );

  assign trigger = eval && (p_max_q != NegInf) && (best_q != NegInf) && hit;
`else
  logic unused_cfg;
  assign unused_cfg = ^{zdrop_i, gap_e_i};
  assign trigger    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StRun;
      StRun: begin
        if (trigger)                     state_d = StDone;
        else if (accept && in_last_i)    state_d = StFlush;
      end
      StFlush: if (trigger || (eval && p_last_q)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      p_valid_q  <= 1'b0;
      p_last_q   <= 1'b0;
      p_max_q    <= NegInf;
      p_loc_q    <= '0;
      best_q     <= NegInf;
      best_loc_q <= '0;
      diag_q     <= '0;
      zdropped_q <= 1'b0;
`ifdef KSW_ZDROP_EN
      zdrop_q    <= '0;
      gap_e_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == StRun);
      busy_q     <= (state_d != StIdle);
      done_q     <= (state_d == StDone);
      if (launch) begin
        p_valid_q  <= 1'b0;
        best_q     <= NegInf;
        best_loc_q <= '0;
        diag_q     <= '0;
        zdropped_q <= 1'b0;
`ifdef KSW_ZDROP_EN
        zdrop_q    <= zdrop_i;
        gap_e_q    <= gap_e_i;
`endif
      end else begin
        if (accept && (diag_q != '1)) diag_q <= diag_q + 1'b1;
        // A triggering evaluation squashes the beat entering P; it is counted only.
        p_valid_q <= accept && !trigger;
        if (accept) begin
          p_max_q  <= in_max_i;
          p_loc_q  <= in_loc_i;
          p_last_q <= in_last_i;
        end
        if (trigger) begin
          zdropped_q <= 1'b1;
        end else if (better) begin
          best_q     <= p_max_q;
          best_loc_q <= p_loc_q;
        end
      end
    end
  end

  assign in_ready_o   = in_ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign best_score_o = best_q;
  assign best_loc_o   = best_loc_q;
  assign diag_cnt_o   = diag_q;
  assign zdropped_o   = zdropped_q;

endmodule

// File: tb/tb_ksw_best_zdrop_tracker.sv
// Scoreboard bench for ksw_best_zdrop_tracker; expectations follow KSW_ZDROP_EN when defined.
module tb_ksw_best_zdrop_tracker;
  import ksw_pkg::*;

  localparam logic signed [15:0] NEG = 16'sh8FFF;
`ifdef KSW_ZDROP_EN
  localparam bit ZdEn = 1'b1;
`else
  localparam bit ZdEn = 1'b0;
`endif

  typedef struct {
    logic signed [15:0] score;
    logic        [31:0] loc;
    logic        [15:0] cnt;
    logic               zd;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start_i = 1'b0;
  logic        [15:0] zdrop_i = '0;
  logic        [7:0]  gap_e_i = '0;
  logic               in_valid_i = 1'b0;
  logic               in_ready_o;
  logic signed [15:0] in_max_i = '0;
  logic        [31:0] in_loc_i = '0;
  logic               in_last_i = 1'b0;
  logic               busy_o, done_o, zdropped_o;
  logic signed [15:0] best_score_o;
  logic        [31:0] best_loc_o;
  logic        [15:0] diag_cnt_o;

  int checks = 0;
  int passed = 0;
  int done_seen = 0;
  exp_t sb[$];
  exp_t last_exp;
  exp_t mon_e;
  logic signed [15:0] bm[$];
  logic        [31:0] bl[$];

  always #5 clk = ~clk;

  ksw_best_zdrop_tracker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .zdrop_i      (zdrop_i),
    .gap_e_i      (gap_e_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_max_i     (in_max_i),
    .in_loc_i     (in_loc_i),
    .in_last_i    (in_last_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .best_score_o (best_score_o),
    .best_loc_o   (best_loc_o),
    .diag_cnt_o   (diag_cnt_o),
    .zdropped_o   (zdropped_o)
  );

  function automatic logic [31:0] loc(input int i, input int j);
    loc_t l;
    l.i = 16'(i);
    l.j = 16'(j);
    return l;
  endfunction

  function automatic void beat(input logic signed [15:0] m, input int i, input int j);
    bm.push_back(m);
    bl.push_back(loc(i, j));
  endfunction

  // Reference model of one extension driven back-to-back.
  function automatic exp_t model(input logic [15:0] zd, input logic [7:0] ge);
    exp_t e;
    int   n;
    n = bm.size();
    e.score = NEG; e.loc = '0; e.cnt = '0; e.zd = 1'b0;
    for (int k = 0; k < n; k++) begin
      e.cnt = e.cnt + 16'd1;
      if (bm[k] == NEG) continue;
      if (bm[k] > e.score) begin
        e.score = bm[k];
        e.loc   = bl[k];
      end else if (ZdEn && e.score != NEG && bm[k] < e.score) begin
        int di, dj, d;
        longint pen, drop;
        di = int'(bl[k][31:16]) - int'(e.loc[31:16]);
        dj = int'(bl[k][15:0]) - int'(e.loc[15:0]);
        d  = di - dj;
        if (d < 0) d = -d;
        pen  = longint'(zd) + longint'(ge) * longint'(d);
        drop = longint'(e.score) - longint'(bm[k]);
        if (drop > pen) begin
          e.zd = 1'b1;
          if (k + 1 < n) e.cnt = e.cnt + 16'd1;
          break;
        end
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done_o) begin
      done_seen++;
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL done_unexpected: done seen, required no pending extension");
      end else begin
        passed++;
        mon_e = sb.pop_front();
        last_exp = mon_e;
        checks++;
        if (best_score_o !== mon_e.score)
          $display("FAIL best_score: got %0d, required %0d", best_score_o, mon_e.score);
        else passed++;
        checks++;
        if (best_loc_o !== mon_e.loc)
          $display("FAIL best_loc: got %h, required %h", best_loc_o, mon_e.loc);
        else passed++;
        checks++;
        if (diag_cnt_o !== mon_e.cnt)
          $display("FAIL diag_cnt: got %0d, required %0d", diag_cnt_o, mon_e.cnt);
        else passed++;
        checks++;
        if (zdropped_o !== mon_e.zd)
          $display("FAIL zdropped: got %0b, required %0b", zdropped_o, mon_e.zd);
        else passed++;
      end
    end
  end

  task automatic run_ext(input logic [15:0] zd, input logic [7:0] ge, input int poke);
    int d0;
    bit stopped;
    stopped = 1'b0;
    sb.push_back(model(zd, ge));
    d0 = done_seen;
    @(negedge clk);
    start_i = 1'b1; zdrop_i = zd; gap_e_i = ge;
    @(negedge clk);
    start_i = 1'b0; zdrop_i = '0; gap_e_i = '0;
    for (int k = 0; k < bm.size(); k++) begin
      if (k > 0) @(negedge clk);
      if (!in_ready_o) begin
        stopped = 1'b1;
        break;
      end
      in_valid_i = 1'b1;
      in_max_i   = bm[k];
      in_loc_i   = bl[k];
      in_last_i  = (k == bm.size() - 1);
      start_i    = (k == poke);
    end
    if (!stopped) @(negedge clk);
    in_valid_i = 1'b0; in_last_i = 1'b0; start_i = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done_seen != d0) break;
      @(posedge clk);
    end
    if (done_seen == d0) begin
      checks++;
      $display("FAIL done_timeout: no done within 30 cycles, required one done");
      if (sb.size() > 0) void'(sb.pop_front());
    end
    bm.delete();
    bl.delete();
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({in_ready_o, busy_o, done_o, zdropped_o} !== 4'b0000)
      $display("FAIL %s_flags: got rdy/busy/done/zd=%b, required 0000", tag,
               {in_ready_o, busy_o, done_o, zdropped_o});
    else passed++;
    checks++;
    if (best_score_o !== NEG)
      $display("FAIL %s_best: got %h, required %h", tag, best_score_o, NEG);
    else passed++;
    checks++;
    if ({best_loc_o, diag_cnt_o} !== 48'd0)
      $display("FAIL %s_loc_cnt: got %h/%0d, required 0/0", tag, best_loc_o, diag_cnt_o);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_monotone();
    beat(16'sd10, 1, 1); beat(16'sd20, 2, 2); beat(16'sd30, 3, 3);
    run_ext(16'd100, 8'd2, -1);
  endtask

  task automatic test_tie_invalid();
    beat(16'sd50, 4, 4); beat(16'sd50, 5, 6); beat(NEG, 0, 0);
    run_ext(16'd100, 8'd2, -1);
  endtask

  task automatic test_zdrop();
    beat(16'sd200, 10, 10); beat(16'sd95, 12, 11); beat(16'sd300, 13, 13);
    run_ext(16'd100, 8'd2, -1);
  endtask

  task automatic test_zdrop_boundary();
    beat(16'sd200, 10, 10); beat(16'sd98, 12, 11); beat(16'sd150, 13, 13);
    run_ext(16'd100, 8'd2, -1);
  endtask

  task automatic test_start_ignored();
    beat(16'sd30, 1, 1); beat(16'sd20, 2, 2); beat(16'sd10, 3, 3);
    run_ext(16'd1000, 8'd0, 1);
  endtask

  task automatic test_hold();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_o, in_ready_o, done_o} !== 3'b000)
      $display("FAIL hold_flags: got busy/rdy/done=%b, required 000",
               {busy_o, in_ready_o, done_o});
    else passed++;
    checks++;
    if (best_score_o !== last_exp.score || best_loc_o !== last_exp.loc ||
        diag_cnt_o !== last_exp.cnt)
      $display("FAIL hold_results: got %0d/%h/%0d, required %0d/%h/%0d", best_score_o,
               best_loc_o, diag_cnt_o, last_exp.score, last_exp.loc, last_exp.cnt);
    else passed++;
  endtask

  task automatic test_mid_reset();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    in_valid_i = 1'b1; in_max_i = 16'sd500; in_loc_i = loc(1, 1);
    @(negedge clk); in_max_i = 16'sd400; in_loc_i = loc(2, 2);
    @(negedge clk); in_valid_i = 1'b0;
    checks++;
    if (best_score_o !== 16'sd500)
      $display("FAIL midrun_best: got %0d, required 500", best_score_o);
    else passed++;
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    beat(16'sd5, 7, 8);
    run_ext(16'd100, 8'd2, -1);
  endtask

  task automatic test_back_to_back();
    beat(16'sd7, 2, 3);
    run_ext(16'd100, 8'd2, -1);
    beat(NEG, 0, 0); beat(-16'sd5, 1, 2); beat(NEG, 0, 0);
    run_ext(16'd100, 8'd2, -1);
  endtask

  initial begin
    test_reset();
    test_monotone();
    test_tie_invalid();
    test_zdrop();
    test_zdrop_boundary();
    test_start_ignored();
    test_hold();
    test_mid_reset();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: %0d pending, required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/ksw_best_zdrop_tracker.md
Name: ksw_best_zdrop_tracker

Overview:
- Sits directly downstream of the per-anti-diagonal compare/max reduction tree in the CIGAR extension engine.
- Consumes one (max score, location) beat per anti-diagonal and tracks the running best score and its location over a whole extension.
- Evaluates the minimap2-style Z-drop test and terminates the extension early when the score falls too far below the best.
- Reports final best score, location, diagonal count and termination cause to the CIGAR traceback controller.

Parameters:
SCORE_W, 16, signed score width
POS_W, 16, width of each coordinate; location = {i[POS_W-1:0], j[POS_W-1:0]}
E_W, 8, unsigned gap-extension penalty width
DIAG_W, 16, anti-diagonal counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin new extension (honoured only in IDLE)
zdrop  in  SCORE_W  Z-drop threshold, unsigned magnitude, sampled at start
gap_e  in  E_W  gap extension penalty, sampled at start
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid & in_ready
in_max  in  SCORE_W  signed anti-diagonal max from reduction tree
in_loc  in  2*POS_W  {i,j} of in_max
in_last  in  1  final anti-diagonal of band
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, results valid
best_score  out  SCORE_W  best score so far
best_loc  out  2*POS_W  location of best_score
diag_cnt  out  DIAG_W  accepted beats this extension
zdropped  out  1  extension terminated by Z-drop

Behaviour:
- Reset: state=IDLE; in_ready=0, busy=0, done=0; best_score=NEG_INF (16'sh8FFF); best_loc=0; diag_cnt=0; zdropped=0; pipe valid=0.
- States:
  - IDLE: start -> RUN. On entry to RUN: latch zdrop/gap_e; clear best_score=NEG_INF, best_loc=0, diag_cnt=0, zdropped=0.
  - RUN: in_ready=1.
  - FLUSH: in_ready=0; wait for the pipe stage to empty.
  - DONE: done=1 for exactly one cycle -> IDLE.
- start is ignored outside IDLE.
- Pipeline: accepted beat registered into stage P at the next edge, with diag_cnt += 1 (saturating at all-ones). Evaluation occurs at the edge after that, so results lag acceptance by 2 cycles.
- Invalid beats: a beat with in_max == NEG_INF is a no-cell diagonal. It counts in diag_cnt, never updates best, and never triggers Z-drop.
- Best update: if P.max > best_score (strict), then best_score <= P.max and best_loc <= P.loc. Ties keep the earlier location.
- Z-drop is evaluated on the pre-update best, only when best_score != NEG_INF and P.max < best_score:
  - di = P.i - best_i, dj = P.j - best_j (signed, POS_W+1 bits); d = |di - dj|.
  - pen = zdrop + gap_e*d, computed in SCORE_W+E_W+POS_W+2 bits unsigned, no overflow.
  - Trigger when (best_score - P.max) > pen, computed in SCORE_W+1 signed.
  - On trigger: zdropped <= 1, best unchanged, state -> DONE. Any beat already in or entering P is discarded and not evaluated; diag_cnt still counts it.
- in_last accepted: state RUN -> FLUSH. Once the last beat has been evaluated, FLUSH -> DONE.
- in_last and Z-drop triggering on the same evaluated beat: zdropped=1 and DONE is entered once.
- Outputs best_score, best_loc, diag_cnt and zdropped hold from DONE until the next start.
- rst_n asserted mid-extension: immediate return to reset values; in-flight beats are lost.
- No back-pressure except the FLUSH and DONE states.

Optional Feature:
- Macro KSW_ZDROP_EN.
- Defined: Z-drop logic as above.
- Undefined: no multiplier or Z-drop compare; zdropped is tied to 0; termination only via in_last. zdrop and gap_e are unused.

Decomposition:
- Package ksw_pkg:
  - NEG_INF = 16'sh8FFF, shared with the compare tree clear value.
  - Typedef loc_t = struct {i, j}.
  - State enum {IDLE, RUN, FLUSH, DONE}.
  - Score and position widths.
- One natural sub-module: ksw_zdrop_eval, a combinational penalty/compare (best, cur, locs, zdrop, gap_e -> trigger), for isolated unit test.

Test Plan:
- Monotone rise: beats 10, 20, 30 at (1,1), (2,2), (3,3) with in_last on the third -> done, best_score=30, best_loc=(3,3), diag_cnt=3, zdropped=0.
- Tie plus invalid beat: beats 50@(4,4), 50@(5,6), NEG_INF, last -> best_loc=(4,4), diag_cnt=3.
- Z-drop:
  - Setup: zdrop=100, gap_e=2; beats 200@(10,10), then 95@(12,11).
  - Arithmetic: d=1, pen=102, drop 105>102.
  - Required: zdropped=1, best_score=200, best_loc=(10,10).
  - A third beat offered back-to-back is discarded and not evaluated.
- No-trigger boundary: same setup but second beat 98 (drop 102, not > 102) -> continues; best_score stays 200.
- Start while busy ignored; rst_n pulse mid-RUN -> all outputs return to reset values; a new start then works normally.
- KSW_ZDROP_EN undefined: rerun the Z-drop scenario -> no termination; done only after in_last; zdropped=0.
